// File: rtl/ads8528_emulator_pkg.sv
// Shared types and constants for the ADS8528 parallel-interface emulator:
// FSM states, channel tags, sample word layout and LFSR definition.
package ads8528_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_e;

  localparam int TAG_W = 3;
  localparam int CNT_W = 13;

  localparam logic [2:0] CH_A0 = 3'd0;
  localparam logic [2:0] CH_A1 = 3'd1;
  localparam logic [2:0] CH_B0 = 3'd2;
  localparam logic [2:0] CH_B1 = 3'd3;
  localparam logic [2:0] CH_C0 = 3'd4;
  localparam logic [2:0] CH_C1 = 3'd5;
  localparam logic [2:0] CH_D0 = 3'd6;
  localparam logic [2:0] CH_D1 = 3'd7;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [TAG_W+CNT_W-1:0] sample_word(
    input logic [TAG_W-1:0] ch,
    input logic [CNT_W-1:0] cnt,
    input logic [1:0]       dither
  );
    return {ch, cnt[CNT_W-1:2], cnt[1:0] ^ dither};
  endfunction

endpackage

// File: rtl/ads8528_emulator_if.sv
// Driver-facing control/status bundle of the ADS8528 emulator (DB bus is a
// separate inout port on the top level).
interface ads8528_emulator_if;
  logic        convst_A;
  logic        convst_B;
  logic        convst_C;
  logic        convst_D;
  logic        read;
  logic        write;
  logic        CS;
  logic        HW;
  logic        PAR;
  logic        Busy;
  logic [15:0] cfg0;
  logic [15:0] cfg1;
  logic [12:0] conv_count;
  logic        overrun;

  modport master (
    output convst_A, convst_B, convst_C, convst_D, read, write, CS, HW, PAR,
    input  Busy, cfg0, cfg1, conv_count, overrun
  );

  modport slave (
    input  convst_A, convst_B, convst_C, convst_D, read, write, CS, HW, PAR,
    output Busy, cfg0, cfg1, conv_count, overrun
  );
endinterface

// File: rtl/ads8528_emulator_edge_sync.sv
// Optional synchronizer chain followed by a history flop; q_o is the
// rising-edge pulse (EDGE=1) or the synchronized level (EDGE=0).
module edge_sync #(
  parameter int             W           = 1,
  parameter int             SYNC_STAGES = 0,
  parameter logic [W-1:0]   RST_VAL     = '0,
  parameter bit             EDGE        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_s;

  if (SYNC_STAGES == 0) begin : g_direct
    assign sync_s = d_i;
  end else begin : g_sync
    logic [W-1:0] ff_q [SYNC_STAGES];

    // Metastability chain towards the local clock
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) ff_q[i] <= RST_VAL;
      end else begin
        ff_q[0] <= d_i;
        for (int i = 1; i < SYNC_STAGES; i++) ff_q[i] <= ff_q[i-1];
      end
    end

    assign sync_s = ff_q[SYNC_STAGES-1];
  end

  if (EDGE) begin : g_edge
    logic [W-1:0] hist_q;

    // Previous synchronized level for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hist_q <= RST_VAL;
      end else begin
        hist_q <= sync_s;
      end
    end

    assign q_o = sync_s & ~hist_q;
  end else begin : g_level
    assign q_o = sync_s;
  end

endmodule

// File: rtl/ads8528_emulator.sv
// ADS8528 parallel-interface responder: conversion FSM, channel-tagged sample
// buffers, config-word capture. Define ADS_EMU_NOISE_EN for LFSR LSB dither.
module ads8528_emulator
  import ads8528_pkg::*;
#(
  parameter int CONV_CYCLES = 16,
  parameter int SYNC_STAGES = 0,
  parameter int NUM_CH      = 8
) (
  input  logic               clk,
  input  logic               rst,
  ads8528_emulator_if.slave  bus,
  inout  wire  [15:0]        DB
);

  logic [3:0]  cv_rise_s;
  logic [1:0]  rw_rise_s;
  logic        cs_lvl_s;
  logic        cs_act_s;
  logic [3:0]  trig_s;
  logic        rd_adv_s;
  logic        wr_cap_s;
  logic        db_oe_s;
  logic [15:0] rd_word_s;
  logic [1:0]  dither_s;

  conv_state_e state_q;
  logic        busy_q;
  logic [7:0]  cnt_q;
  logic [3:0]  trig_q;
  logic        overrun_q;
  logic [12:0] conv_cnt_q;
  logic [2:0]  rd_idx_q;
  logic        wr_idx_q;
  logic [15:0] cfg0_q;
  logic [15:0] cfg1_q;
  logic [15:0] db_q;
  logic [15:0] buf_q [NUM_CH];

  edge_sync #(.W(4), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(4'b0000), .EDGE(1'b1)) u_cv_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({bus.convst_D, bus.convst_C, bus.convst_B, bus.convst_A}),
    .q_o (cv_rise_s)
  );

  // RD/WR idle high, so reset history high to avoid a phantom edge
  edge_sync #(.W(2), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(2'b11), .EDGE(1'b1)) u_rw_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({bus.write, bus.read}),
    .q_o (rw_rise_s)
  );

  if (SYNC_STAGES == 0) begin : g_cs_direct
    assign cs_lvl_s = bus.CS;
  end else begin : g_cs_sync
    edge_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE(1'b0)) u_cs_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.CS),
      .q_o (cs_lvl_s)
    );
  end

  assign cs_act_s = ~cs_lvl_s;
  assign trig_s   = cv_rise_s & {4{cs_act_s}};
  assign rd_adv_s = rw_rise_s[0] & cs_act_s;
  assign wr_cap_s = rw_rise_s[1] & cs_act_s;

  // Read data comes straight off the raw pins so it is valid as RD falls
  assign rd_word_s = buf_q[rd_idx_q];
  assign db_oe_s   = ~bus.CS & ~bus.read & bus.write;
  assign DB        = db_oe_s ? rd_word_s : 16'hzzzz;

`ifdef ADS_EMU_NOISE_EN
  logic [15:0] lfsr_q;

  // Dither source, advanced once per completed conversion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == LOAD) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign dither_s = lfsr_q[1:0];
`else
  assign dither_s = 2'b00;
`endif

  // Config-word capture from the previous-cycle DB sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q     <= 16'h0000;
      cfg0_q   <= 16'h0000;
      cfg1_q   <= 16'h0000;
      wr_idx_q <= 1'b0;
    end else begin
      db_q <= DB;
      if (wr_cap_s) begin
        if (!wr_idx_q) begin
          cfg0_q <= db_q;
        end else begin
          cfg1_q <= db_q;
        end
        wr_idx_q <= ~wr_idx_q;
      end
    end
  end

  // Conversion FSM, sample buffers and read pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= 8'd0;
      trig_q     <= 4'b0000;
      overrun_q  <= 1'b0;
      conv_cnt_q <= 13'd0;
      rd_idx_q   <= 3'd0;
      for (int i = 0; i < NUM_CH; i++) buf_q[i] <= 16'h0000;
    end else begin
      if (rd_adv_s) begin
        rd_idx_q <= rd_idx_q + 3'd1;
      end
      case (state_q)
        IDLE: begin
          if (|trig_s) begin
            state_q <= CONV;
            busy_q  <= 1'b1;
            cnt_q   <= 8'(CONV_CYCLES - 1);
            trig_q  <= trig_s;
          end
        end
        CONV: begin
          if (|cv_rise_s) overrun_q <= 1'b1;
          if (cnt_q == 8'd0) begin
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        LOAD: begin
          if (|cv_rise_s) overrun_q <= 1'b1;
          if (trig_q[0]) begin
            buf_q[CH_A0] <= sample_word(CH_A0, conv_cnt_q, dither_s);
            buf_q[CH_A1] <= sample_word(CH_A1, conv_cnt_q, dither_s);
          end
          if (trig_q[1]) begin
            buf_q[CH_B0] <= sample_word(CH_B0, conv_cnt_q, dither_s);
            buf_q[CH_B1] <= sample_word(CH_B1, conv_cnt_q, dither_s);
          end
          if (trig_q[2]) begin
            buf_q[CH_C0] <= sample_word(CH_C0, conv_cnt_q, dither_s);
            buf_q[CH_C1] <= sample_word(CH_C1, conv_cnt_q, dither_s);
          end
          if (trig_q[3]) begin
            buf_q[CH_D0] <= sample_word(CH_D0, conv_cnt_q, dither_s);
            buf_q[CH_D1] <= sample_word(CH_D1, conv_cnt_q, dither_s);
          end
          conv_cnt_q <= conv_cnt_q + 13'd1;
          rd_idx_q   <= 3'd0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy       = busy_q;
  assign bus.cfg0       = cfg0_q;
  assign bus.cfg1       = cfg1_q;
  assign bus.conv_count = conv_cnt_q;
  assign bus.overrun    = overrun_q;

endmodule
